// File: rtl/ruleid_packer.sv
// ruleid_packer
//   Packs a stream of matched rule IDs into wide words for the capture stage.
//   Zero IDs ("no match") are dropped; non-zero IDs fill lanes little-endian
//   (lane k at bits [RID_WIDTH*k +: RID_WIDTH]). A word is emitted when the
//   last lane is written or when in_last flushes a non-empty partial word.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_ruleid   rule ID, 0 = no match
//   in_valid    in_ruleid / in_last valid
//   in_last     last ID of a packet, flushes the partial word
//   in_ready    block can accept this cycle
//   out_data    packed word
//   out_valid   out_data valid
//   out_ready   consumer accepts out_data
//   out_fill    number of valid lanes in out_data (1..LANES)
//   stat_words  words emitted (wraps)
//   stat_ids    non-zero IDs packed (wraps)
module ruleid_packer #(
    parameter int RID_WIDTH = 16,
    parameter int OUT_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RID_WIDTH-1:0] in_ruleid,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_fill,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_ids
);

    localparam int LANES = OUT_WIDTH / RID_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                 out_valid_reg;
    logic [OUT_WIDTH-1:0] out_data_reg;
    logic [5:0]           out_fill_reg;
    logic [OUT_WIDTH-1:0] asm_reg;
    logic [OUT_WIDTH-1:0] asm_next;
    logic [IDX_W-1:0]     idx_reg;
    logic [31:0]          stat_words_reg;
    logic [31:0]          stat_ids_reg;
    // Low during reset and for the first edge after release, so nothing is
    // accepted on the edge where reset was still being removed.
    logic                 run_reg;

    logic       accept;
    logic       wr;
    logic       last_lane;
    logic [5:0] fill_next;
    logic       complete;

    // Combinational path from out_ready: a draining output frees the input
    // in the same cycle, so there is no bubble after a drain.
    assign in_ready  = run_reg & (~out_valid_reg | out_ready);
    assign accept    = in_valid & in_ready;
    assign wr        = accept & (in_ruleid != '0);
    assign last_lane = (idx_reg == IDX_W'(LANES - 1));
    // Fill of the word including the current ID when it is being written.
    assign fill_next = 6'(idx_reg) + 6'(wr);
    assign complete  = accept & ((wr & last_lane) | (in_last & (fill_next != 6'd0)));

    // Assembly word with the current ID dropped into lane idx.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign asm_next[gi*RID_WIDTH +: RID_WIDTH] =
                (wr && (idx_reg == IDX_W'(gi))) ? in_ruleid
                                                : asm_reg[gi*RID_WIDTH +: RID_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_fill_reg   <= '0;
            asm_reg        <= '0;
            idx_reg        <= '0;
            stat_words_reg <= '0;
            stat_ids_reg   <= '0;
        end else begin
            run_reg <= 1'b1;
            if (complete) begin
                // Reload covers both an empty output and a same-cycle drain.
                out_data_reg   <= asm_next;
                out_fill_reg   <= fill_next;
                out_valid_reg  <= 1'b1;
                asm_reg        <= '0;
                idx_reg        <= '0;
                stat_words_reg <= stat_words_reg + 32'd1;
            end else begin
                if (wr) begin
                    asm_reg <= asm_next;
                    idx_reg <= idx_reg + IDX_W'(1);
                end
                if (out_valid_reg && out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
            if (wr) begin
                stat_ids_reg <= stat_ids_reg + 32'd1;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_fill   = out_fill_reg;
    assign stat_words = stat_words_reg;
    assign stat_ids   = stat_ids_reg;

endmodule

// File: tb/tb_ruleid_packer.sv
module tb_ruleid_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  in_ruleid;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [5:0]   out_fill;
    logic [31:0]  stat_words;
    logic [31:0]  stat_ids;

    ruleid_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_ruleid  (in_ruleid),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fill   (out_fill),
        .stat_words (stat_words),
        .stat_ids   (stat_ids)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [511:0] d;
        logic [5:0]   f;
    } word_t;
    word_t cap_q[$];

    // Words transferred: out_ready is only changed just after posedge, so a
    // valid&ready seen at negedge is the transfer on the following posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            cap_q.push_back('{out_data, out_fill});
        end
    end

    typedef struct {
        logic        v;
        logic [15:0] rid;
        logic        last;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [5:0]  exp_fill;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [15:0] lane(input logic [511:0] d, input int k);
        return d[16*k +: 16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] rid, input logic last);
        in_valid  = v;
        in_ruleid = rid;
        in_last   = last;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        word_t w;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_fill", 64'(out_fill), 64'd0);
        chk("rst_out_data_lo", out_data[63:0], 64'd0);
        chk("rst_stat_words", 64'(stat_words), 64'd0);
        chk("rst_stat_ids", 64'(stat_ids), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_blocked", 64'(in_ready), 64'd0);
        tick();
        chk("rst_release_ready", 64'(in_ready), 64'd1);

        // ---------------- full word 1..32 with in_last ----------------
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 16'(i + 1), i == 31);
            tick();
            if (i == 30) chk("t1_no_early_valid", 64'(out_valid), 64'd0);
        end
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_fill", 64'(out_fill), 64'd32);
        chk("t1_lane0", 64'(lane(out_data, 0)), 64'h0001);
        chk("t1_lane31", 64'(lane(out_data, 31)), 64'h0020);
        chk("t1_stat_words", 64'(stat_words), 64'd1);
        chk("t1_stat_ids", 64'(stat_ids), 64'd32);
        drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("t1_drained", 64'(out_valid), 64'd0);
        chk("t1_word_count", 64'(cap_q.size()), 64'd1);
        cap_q.delete();

        // ---------------- table: zero skip, zero packet, stall, drain+reload ----------------
        //            v     rid      last  ordy  rdy   ov    fill
        vecs[0]  = '{1'b1, 16'h00AA, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[2]  = '{1'b1, 16'h00BB, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[3]  = '{1'b1, 16'h00CC, 1'b1, 1'b1, 1'b1, 1'b1, 6'd3};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[5]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[6]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[9]  = '{1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 1'b1, 6'd1};
        vecs[10] = '{1'b1, 16'h0022, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[11] = '{1'b1, 16'h0022, 1'b1, 1'b1, 1'b1, 1'b1, 6'd1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].rid, vecs[i].last);
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("tab%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("tab%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) chk($sformatf("tab%0d_out_fill", i), 64'(out_fill), 64'(vecs[i].exp_fill));
        end
        chk("tab_stat_words", 64'(stat_words), 64'd4);
        chk("tab_stat_ids", 64'(stat_ids), 64'd37);
        chk("tab_word_count", 64'(cap_q.size()), 64'd3);
        if (cap_q.size() == 3) begin
            w = cap_q[0];
            chk("tab_w0_lane0", 64'(lane(w.d, 0)), 64'h00AA);
            chk("tab_w0_lane1", 64'(lane(w.d, 1)), 64'h00BB);
            chk("tab_w0_lane2", 64'(lane(w.d, 2)), 64'h00CC);
            chk("tab_w0_upper_zero", 64'(w.d[511:48] == '0), 64'd1);
            chk("tab_w0_fill", 64'(w.f), 64'd3);
            chk("tab_w1_lane0", 64'(lane(cap_q[1].d, 0)), 64'h0011);
            chk("tab_w2_lane0", 64'(lane(cap_q[2].d, 0)), 64'h0022);
            chk("tab_w2_lane1", 64'(lane(cap_q[2].d, 1)), 64'h0000);
        end
        cap_q.delete();

        // ---------------- 40 IDs with out_ready low from the start ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 16'h1001 + 16'(i), 1'b0);
            #1;
            chk($sformatf("t4_ready_id%0d", i + 1), 64'(in_ready), 64'd1);
            tick();
        end
        chk("t4_w0_valid", 64'(out_valid), 64'd1);
        chk("t4_w0_fill", 64'(out_fill), 64'd32);
        drive(1'b1, 16'h1021, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t4_stall%0d_ready", c), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("t4_stall%0d_fill", c), 64'(out_fill), 64'd32);
            chk($sformatf("t4_stall%0d_lane0", c), 64'(lane(out_data, 0)), 64'h1001);
            chk($sformatf("t4_stall%0d_lane31", c), 64'(lane(out_data, 31)), 64'h1020);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t4_after_drain_valid", 64'(out_valid), 64'd0);
        for (int i = 33; i < 40; i++) begin
            drive(1'b1, 16'h1001 + 16'(i), i == 39);
            tick();
        end
        chk("t4_w1_valid", 64'(out_valid), 64'd1);
        chk("t4_w1_fill", 64'(out_fill), 64'd8);
        chk("t4_w1_lane0", 64'(lane(out_data, 0)), 64'h1021);
        chk("t4_w1_lane7", 64'(lane(out_data, 7)), 64'h1028);
        chk("t4_w1_lane8", 64'(lane(out_data, 8)), 64'h0000);
        drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("t4_word_count", 64'(cap_q.size()), 64'd2);
        chk("t4_stat_words", 64'(stat_words), 64'd6);
        chk("t4_stat_ids", 64'(stat_ids), 64'd77);
        cap_q.delete();

        // ---------------- reset in mid-packet ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h2001 + 16'(i), 1'b0);
            tick();
        end
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        #1;
        chk("t6_rst_stat_ids", 64'(stat_ids), 64'd0);
        chk("t6_rst_stat_words", 64'(stat_words), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 16'h7777, 1'b0);
        #1;
        chk("t6_release_blocked", 64'(in_ready), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h3001 + 16'(i), i == 4);
            #1;
            chk($sformatf("t6_ready_id%0d", i + 1), 64'(in_ready), 64'd1);
            tick();
        end
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_fill", 64'(out_fill), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t6_lane%0d", k), 64'(lane(out_data, k)), 64'h3001 + 64'(k));
        end
        chk("t6_upper_zero", 64'(out_data[511:80] == '0), 64'd1);
        chk("t6_stat_words", 64'(stat_words), 64'd1);
        chk("t6_stat_ids", 64'(stat_ids), 64'd5);
        drive(1'b0, 16'h0, 1'b0);
        tick();
        chk("t6_word_count", 64'(cap_q.size()), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
